instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, issues single-outstanding word
// fetches to instruction memory, and buffers returned words with their PCs
// in a small FIFO feeding the decoder. Redirects flush the buffer and
// discard any response still in flight.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_pending_pc;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_fifo_word [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc   [FIFO_DEPTH];

    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_inst_valid;
    logic               w_unused_redirect_lsb;

    // Redirect targets are forced word-aligned; the low bits carry no meaning.
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];

    // Next-state and request-valid decode; a response is only accepted into
    // the buffer from WAIT, and a redirect in that same cycle still kills it.
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        unique case (r_state)
            ST_ISSUE: begin
                w_req_valid = !reset && (r_count < DEPTH_C) && !redirect_valid;
                if (w_req_valid && imem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nxt = ST_ISSUE;
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                // The outstanding response is consumed here even if another
                // redirect arrives, otherwise DROP would wait forever.
                if (imem_resp_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_ISSUE;
        endcase
    end

    assign w_req_fire   = w_req_valid && imem_req_ready;
    assign w_push       = (r_state == ST_WAIT) && imem_resp_valid && !redirect_valid;
    assign w_inst_valid = (r_count != '0) && !redirect_valid && !reset;
    assign w_pop        = w_inst_valid && inst_ready;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = w_inst_valid;
    assign inst_word      = r_fifo_word[r_rd_ptr];
    assign inst_pc        = r_fifo_pc[r_rd_ptr];

    // Control state: FSM, PC, pending PC and FIFO bookkeeping; redirect wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ISSUE;
            r_pc         <= {RESET_PC[31:2], 2'b00};
            r_pending_pc <= 32'h0000_0000;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_pc     <= {redirect_pc[31:2], 2'b00};
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc         <= r_pc + 32'd4;
                    r_pending_pc <= r_pc;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // Buffer storage: data only, written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_word[r_wr_ptr] <= imem_resp_data;
            r_fifo_pc[r_wr_ptr]   <= r_pending_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios push expected
// request addresses and decoded instructions into queues; a monitor pops and
// compares on every request handshake and every decode handshake.
module tb_instruction_fetch;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_req [$];
    logic [63:0] exp_inst [$];

    int          lat = 1;
    int          budget = 0;
    int          resp_cnt = 0;
    logic [31:0] resp_addr = 32'h0;

    instruction_fetch #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_word       (inst_word),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory contents model.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h0050_0093;
            32'h0000_1004: return 32'h00A0_0113;
            default:       return a ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive point: just after a rising edge. Sample point: 2ns before one.
    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_hs(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample_pt();
            if (!reset && imem_req_valid && imem_req_ready) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: no request handshake within 20 cycles", name);
        end
    endtask

    task automatic wait_iv(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample_pt();
            if (inst_valid) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: inst_valid not seen within 20 cycles", name);
        end
        drive_pt();
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while ((exp_req.size() != 0 || exp_inst.size() != 0) && n < maxc) begin
            sample_pt();
            #1;
            n++;
        end
        tests++;
        if (exp_req.size() != 0 || exp_inst.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d requests and %0d instructions still expected after %0d cycles",
                     name, exp_req.size(), exp_inst.size(), n);
            exp_req.delete();
            exp_inst.delete();
        end
        drive_pt();
    endtask

    // Memory responder: ready follows the request budget, responses return
    // lat cycles after acceptance.
    initial begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            imem_req_ready = (budget > 0);
            if (resp_cnt == 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(resp_addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
            if (resp_cnt > 0) resp_cnt--;
            #3;
            if (!reset && imem_req_valid && imem_req_ready) begin
                resp_cnt  = lat;
                resp_addr = imem_req_addr;
                if (budget > 0) budget--;
            end
        end
    end

    // Monitor: compare every handshake against the scoreboard queues.
    initial begin
        logic [31:0] ea;
        logic [63:0] ei;
        forever begin
            sample_pt();
            if (!reset && imem_req_valid && imem_req_ready) begin
                if (exp_req.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_unexpected: request at %h, none expected", imem_req_addr);
                end else begin
                    ea = exp_req.pop_front();
                    check("req_addr", imem_req_addr, ea);
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL inst_unexpected: word %h pc %h, none expected", inst_word, inst_pc);
                end else begin
                    ei = exp_inst.pop_front();
                    check("inst_word", inst_word, ei[63:32]);
                    check("inst_pc", inst_pc, ei[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // Reset state
        repeat (3) sample_pt();
        check_bit("rst_req_valid", imem_req_valid, 1'b0);
        check_bit("rst_inst_valid", inst_valid, 1'b0);

        // Basic in-order fetch from RESET_PC
        exp_req.push_back(32'h0000_1000);
        exp_req.push_back(32'h0000_1004);
        exp_inst.push_back({32'h0050_0093, 32'h0000_1000});
        exp_inst.push_back({32'h00A0_0113, 32'h0000_1004});
        lat    = 1;
        budget = 2;
        drive_pt();
        reset      = 1'b0;
        inst_ready = 1'b1;
        sample_pt();
        check_bit("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, RPC);
        drain("basic", 40);

        // Decode stalled: buffer fills to depth and requests stop
        inst_ready = 1'b0;
        budget     = 4;
        exp_req.push_back(32'h0000_1008);
        exp_req.push_back(32'h0000_100C);
        repeat (10) sample_pt();
        check_bit("full_req_valid", imem_req_valid, 1'b0);
        check_bit("full_inst_valid", inst_valid, 1'b1);
        check("full_head_pc", inst_pc, 32'h0000_1008);
        check("full_req_count", 32'(budget), 32'd2);
        drive_pt();
        budget = 1;
        exp_req.push_back(32'h0000_1010);
        exp_inst.push_back({word_of(32'h0000_1008), 32'h0000_1008});
        exp_inst.push_back({word_of(32'h0000_100C), 32'h0000_100C});
        exp_inst.push_back({word_of(32'h0000_1010), 32'h0000_1010});
        inst_ready = 1'b1;
        drain("stall", 40);

        // Redirect during WAIT with a late response, buffer holding one entry
        inst_ready = 1'b0;
        budget     = 1;
        exp_req.push_back(32'h0000_1014);
        wait_iv("pre_redirect_fill");
        lat    = 3;
        budget = 1;
        exp_req.push_back(32'h0000_1018);
        wait_hs("redirect_wait_hs");
        drive_pt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        sample_pt();
        check_bit("redir_inst_valid", inst_valid, 1'b0);
        check_bit("redir_req_valid", imem_req_valid, 1'b0);
        drive_pt();
        redirect_valid = 1'b0;
        sample_pt();
        check_bit("redir_flushed", inst_valid, 1'b0);
        drive_pt();
        budget     = 1;
        inst_ready = 1'b1;
        exp_req.push_back(32'h0000_2000);
        exp_inst.push_back({word_of(32'h0000_2000), 32'h0000_2000});
        drain("redirect_drop", 40);

        // Redirect in the same cycle as the WAIT response
        lat    = 2;
        budget = 2;
        exp_req.push_back(32'h0000_2004);
        exp_req.push_back(32'h0000_3000);
        exp_inst.push_back({word_of(32'h0000_3000), 32'h0000_3000});
        wait_hs("redirect_resp_hs");
        drive_pt();
        drive_pt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        drive_pt();
        redirect_valid = 1'b0;
        sample_pt();
        check_bit("redir_resp_req_valid", imem_req_valid, 1'b1);
        check("redir_resp_req_addr", imem_req_addr, 32'h0000_3000);
        drain("redirect_resp", 40);

        // Push and pop in the same cycle with one entry buffered
        inst_ready = 1'b0;
        lat        = 1;
        budget     = 1;
        exp_req.push_back(32'h0000_3004);
        exp_req.push_back(32'h0000_3008);
        exp_inst.push_back({word_of(32'h0000_3004), 32'h0000_3004});
        exp_inst.push_back({word_of(32'h0000_3008), 32'h0000_3008});
        wait_iv("pushpop_fill");
        budget = 1;
        wait_hs("pushpop_hs");
        drive_pt();
        inst_ready = 1'b1;
        sample_pt();
        sample_pt();
        check_bit("pushpop_valid", inst_valid, 1'b1);
        check("pushpop_head_pc", inst_pc, 32'h0000_3008);
        drain("pushpop", 40);

        // PC wrap from the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        sample_pt();
        check_bit("wrap_redir_req_masked", imem_req_valid, 1'b0);
        drive_pt();
        redirect_valid = 1'b0;
        budget         = 2;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        exp_inst.push_back({word_of(32'hFFFF_FFFC), 32'hFFFF_FFFC});
        exp_inst.push_back({word_of(32'h0000_0000), 32'h0000_0000});
        drain("wrap", 40);

        // Reset during WAIT with a buffered entry and a response in flight
        inst_ready = 1'b0;
        budget     = 1;
        exp_req.push_back(32'h0000_0004);
        wait_iv("reset_fill");
        lat    = 4;
        budget = 1;
        exp_req.push_back(32'h0000_0008);
        wait_hs("reset_wait_hs");
        drive_pt();
        reset  = 1'b1;
        budget = 0;
        sample_pt();
        check_bit("midrst_inst_valid", inst_valid, 1'b0);
        check_bit("midrst_req_valid", imem_req_valid, 1'b0);
        drive_pt();
        sample_pt();
        check_bit("midrst_req_valid2", imem_req_valid, 1'b0);
        drive_pt();
        reset = 1'b0;
        sample_pt();
        check_bit("postrst_req_valid", imem_req_valid, 1'b1);
        check("postrst_req_addr", imem_req_addr, RPC);
        sample_pt();
        sample_pt();
        check_bit("stale_resp_ignored", inst_valid, 1'b0);
        drive_pt();
        lat        = 1;
        budget     = 1;
        inst_ready = 1'b1;
        exp_req.push_back(RPC);
        exp_inst.push_back({32'h0050_0093, RPC});
        drain("after_reset", 40);

        repeat (3) sample_pt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
